// File: rtl/div_writeback_unit.sv
// Divider result writeback: buffers 64-bit results in an in-order FIFO and drains them into the
// 32-bit register-file write port, with N/Z flag strobes. Optional forwarding lookup: DIV_WB_FORWARD_EN.
module div_writeback_unit #(
    parameter int DEPTH    = 4,
    parameter bit WRITE_HI = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        DIV_S,
    input  logic        DIV_WB,
    input  logic [63:0] DIV_Result,
    input  logic [3:0]  DIV_Address,
    input  logic        RF_GNT,
    output logic        RF_WE,
    output logic [3:0]  RF_WADDR,
    output logic [31:0] RF_WDATA,
    output logic        FLAG_WE,
    output logic        FLAG_N,
    output logic        FLAG_Z,
    output logic        DIV_STALL,
    output logic        OVERFLOW
`ifdef DIV_WB_FORWARD_EN
    ,
    input  logic [3:0]  FWD_ADDR,
    output logic        FWD_HIT,
    output logic [31:0] FWD_DATA
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_STALL = CW'(DEPTH - 2);

    typedef struct packed {
        logic        s;
        logic        wb;
        logic [63:0] result;
        logic [3:0]  rd;
    } entry_t;

    // IDLE: waiting for an entry | LO: low half requested | HI: high half requested | FLG: flags-only entry
    typedef enum logic [1:0] {IDLE, LO, HI, FLG} state_t;

    state_t          state_q, state_d;
    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            flag_we_q, flag_we_d;
    logic            flag_n_q, flag_n_d;
    logic            flag_z_q, flag_z_d;
    logic            overflow_q, overflow_d;

    entry_t          head;
    logic            next_wb;
    logic            pop;
    logic            push;
    logic            in_valid;
    logic            flag_set;

    always_comb begin
        head      = mem_q[rd_ptr_q];
        next_wb   = mem_q[rd_ptr_q + PTR_ONE].wb;
        state_d   = state_q;
        pop       = 1'b0;
        flag_set  = 1'b0;
        RF_WE     = 1'b0;
        RF_WADDR  = 4'd0;
        RF_WDATA  = 32'd0;

        case (state_q)
            IDLE: begin
                if (count_q != '0) state_d = head.wb ? LO : FLG;
            end
            LO: begin
                RF_WE    = 1'b1;
                RF_WADDR = head.rd;
                RF_WDATA = head.result[31:0];
                if (RF_GNT) begin
                    flag_set = head.s;
                    if (WRITE_HI) state_d = HI;
                    else          pop     = 1'b1;
                end
            end
            HI: begin
                RF_WE    = 1'b1;
                RF_WADDR = head.rd + 4'd1;
                RF_WDATA = head.result[63:32];
                if (RF_GNT) pop = 1'b1;
            end
            FLG: begin
                pop      = 1'b1;
                flag_set = head.s;
            end
            default: state_d = IDLE;
        endcase

        // Chain straight into the following entry without an IDLE bubble
        if (pop) begin
            if (count_q > CNT_ONE) state_d = next_wb ? LO : FLG;
            else                   state_d = IDLE;
        end

        in_valid   = DIV_WB | DIV_S;
        push       = in_valid && ((count_q != CNT_FULL) || pop);
        overflow_d = overflow_q | (in_valid & ~push);

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = '{s: DIV_S, wb: DIV_WB, result: DIV_Result, rd: DIV_Address};

        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        flag_we_d = flag_set;
        flag_n_d  = flag_n_q;
        flag_z_d  = flag_z_q;
        if (flag_set) begin
            flag_n_d = WRITE_HI ? head.result[63] : head.result[31];
            flag_z_d = WRITE_HI ? (head.result == 64'd0) : (head.result[31:0] == 32'd0);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            mem_q      <= '{default: '0};
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            flag_we_q  <= 1'b0;
            flag_n_q   <= 1'b0;
            flag_z_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            flag_we_q  <= flag_we_d;
            flag_n_q   <= flag_n_d;
            flag_z_q   <= flag_z_d;
            overflow_q <= overflow_d;
        end
    end

    // Registered count already accounts for the two divider stages still in flight
    assign DIV_STALL = (count_q >= CNT_STALL);
    assign FLAG_WE   = flag_we_q;
    assign FLAG_N    = flag_n_q;
    assign FLAG_Z    = flag_z_q;
    assign OVERFLOW  = overflow_q;

`ifdef DIV_WB_FORWARD_EN
    entry_t        fwd_e;
    logic [AW-1:0] fwd_idx;

    // Scan oldest to youngest so later matches override earlier ones
    always_comb begin
        FWD_HIT  = 1'b0;
        FWD_DATA = 32'd0;
        fwd_e    = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + AW'(i);
            fwd_e   = mem_q[fwd_idx];
            if ((CW'(i) < count_q) && fwd_e.wb) begin
                if (!(i == 0 && state_q == HI) && (fwd_e.rd == FWD_ADDR)) begin
                    FWD_HIT  = 1'b1;
                    FWD_DATA = fwd_e.result[31:0];
                end
                if (WRITE_HI && ((fwd_e.rd + 4'd1) == FWD_ADDR)) begin
                    FWD_HIT  = 1'b1;
                    FWD_DATA = fwd_e.result[63:32];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_div_writeback_unit.sv
// Directed bench for div_writeback_unit: single-entry vector table plus multi-cycle sequences.
module tb_div_writeback_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        DIV_S = 1'b0;
    logic        DIV_WB = 1'b0;
    logic [63:0] DIV_Result = 64'd0;
    logic [3:0]  DIV_Address = 4'd0;
    logic        RF_GNT = 1'b1;
    logic        RF_WE;
    logic [3:0]  RF_WADDR;
    logic [31:0] RF_WDATA;
    logic        FLAG_WE;
    logic        FLAG_N;
    logic        FLAG_Z;
    logic        DIV_STALL;
    logic        OVERFLOW;

    div_writeback_unit #(.DEPTH(4), .WRITE_HI(1'b1)) dut (
        .CLK(CLK), .RST(RST), .DIV_S(DIV_S), .DIV_WB(DIV_WB), .DIV_Result(DIV_Result),
        .DIV_Address(DIV_Address), .RF_GNT(RF_GNT), .RF_WE(RF_WE), .RF_WADDR(RF_WADDR),
        .RF_WDATA(RF_WDATA), .FLAG_WE(FLAG_WE), .FLAG_N(FLAG_N), .FLAG_Z(FLAG_Z),
        .DIV_STALL(DIV_STALL), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        s;
        logic        wb;
        logic [3:0]  rd;
        logic [63:0] res;
        logic [3:0]  lo_a;
        logic [31:0] lo_d;
        logic [3:0]  hi_a;
        logic [31:0] hi_d;
        logic        fwe;
        logic        n;
        logic        z;
    } vec_t;

    vec_t vecs [6];
    int   n_pass = 0;
    int   n_total = 0;
    logic exp_n = 1'b0;
    logic exp_z = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic enq(input logic s, input logic wb, input logic [3:0] rd, input logic [63:0] res);
        DIV_S = s; DIV_WB = wb; DIV_Address = rd; DIV_Result = res;
    endtask

    task automatic clr;
        DIV_S = 1'b0; DIV_WB = 1'b0; DIV_Address = 4'd0; DIV_Result = 64'd0;
    endtask

    task automatic row(input string nm, input logic we, input logic [3:0] a, input logic [31:0] d,
                       input logic fwe);
        chk({nm, "_we"}, 64'(RF_WE), 64'(we));
        if (we) begin
            chk({nm, "_addr"}, 64'(RF_WADDR), 64'(a));
            chk({nm, "_data"}, 64'(RF_WDATA), 64'(d));
        end
        chk({nm, "_flag_we"}, 64'(FLAG_WE), 64'(fwe));
    endtask

    logic [3:0]  wr_a [$];
    logic [31:0] wr_d [$];
    int          late_writes;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 4'd3,  64'h0000_0002_0000_0007, 4'd3,  32'h0000_0007, 4'd4,  32'h0000_0002, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 4'd15, 64'hFFFF_FFFF_8000_0000, 4'd15, 32'h8000_0000, 4'd0,  32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 4'd5,  64'h0000_0000_0000_0000, 4'd0,  32'h0,         4'd0,  32'h0,         1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 4'd7,  64'h0000_0000_0000_0000, 4'd7,  32'h0000_0000, 4'd8,  32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 4'd1,  64'h0000_0001_0000_0000, 4'd1,  32'h0000_0000, 4'd2,  32'h0000_0001, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 4'd0,  64'h8000_0000_0000_0001, 4'd0,  32'h0,         4'd0,  32'h0,         1'b1, 1'b1, 1'b0};

        // Reset state
        RST = 1'b1;
        tick; tick;
        chk("rst_we",       64'(RF_WE), 0);
        chk("rst_waddr",    64'(RF_WADDR), 0);
        chk("rst_wdata",    64'(RF_WDATA), 0);
        chk("rst_flags",    64'({FLAG_WE, FLAG_N, FLAG_Z}), 0);
        chk("rst_stall",    64'(DIV_STALL), 0);
        chk("rst_overflow", 64'(OVERFLOW), 0);
        RST = 1'b0;
        tick;

        // Single entries with RF_GNT tied high
        RF_GNT = 1'b1;
        for (int i = 0; i < 6; i++) begin
            enq(vecs[i].s, vecs[i].wb, vecs[i].rd, vecs[i].res);
            tick;
            clr;
            chk($sformatf("v%0d_k_we", i), 64'(RF_WE), 0);
            chk($sformatf("v%0d_k_stall", i), 64'(DIV_STALL), 0);
            tick;
            row($sformatf("v%0d_k1", i), vecs[i].wb, vecs[i].lo_a, vecs[i].lo_d, 1'b0);
            tick;
            row($sformatf("v%0d_k2", i), vecs[i].wb, vecs[i].hi_a, vecs[i].hi_d, vecs[i].fwe);
            if (vecs[i].fwe) begin
                exp_n = vecs[i].n;
                exp_z = vecs[i].z;
            end
            chk($sformatf("v%0d_k2_n", i), 64'(FLAG_N), 64'(exp_n));
            chk($sformatf("v%0d_k2_z", i), 64'(FLAG_Z), 64'(exp_z));
            tick;
            row($sformatf("v%0d_k3", i), 1'b0, 4'd0, 32'd0, 1'b0);
            chk($sformatf("v%0d_k3_hold", i), 64'({FLAG_N, FLAG_Z}), 64'({exp_n, exp_z}));
        end

        // Grant withheld: request must hold stable, then drain in order
        RF_GNT = 1'b0;
        enq(1'b0, 1'b1, 4'd2, 64'h0000_0011_0000_0022);
        tick;
        enq(1'b0, 1'b1, 4'd9, 64'h0000_0099_0000_0088);
        tick;
        clr;
        chk("hold_stall", 64'(DIV_STALL), 1);
        for (int j = 0; j < 5; j++) begin
            row($sformatf("hold_c%0d", j), 1'b1, 4'd2, 32'h22, 1'b0);
            if (j < 4) tick;
        end
        RF_GNT = 1'b1;
        tick; row("hold_hiA", 1'b1, 4'd3,  32'h11, 1'b0);
        tick; row("hold_loB", 1'b1, 4'd9,  32'h88, 1'b0);
        tick; row("hold_hiB", 1'b1, 4'd10, 32'h99, 1'b0);
        tick; row("hold_end", 1'b0, 4'd0,  32'h0,  1'b0);

        // Flags-only entry between two writeback entries
        enq(1'b0, 1'b1, 4'd4, 64'h0000_0041_0000_0040);
        tick;
        enq(1'b1, 1'b0, 4'd12, 64'd0);
        tick;
        row("fb_loW1", 1'b1, 4'd4, 32'h40, 1'b0);
        enq(1'b0, 1'b1, 4'd6, 64'h0000_0061_0000_0060);
        tick;
        clr;
        row("fb_hiW1", 1'b1, 4'd5, 32'h41, 1'b0);
        tick; row("fb_flg",  1'b0, 4'd0, 32'h0,  1'b0);
        tick; row("fb_loW2", 1'b1, 4'd6, 32'h60, 1'b1);
        chk("fb_flag_nz", 64'({FLAG_N, FLAG_Z}), 64'({1'b0, 1'b1}));
        tick; row("fb_hiW2", 1'b1, 4'd7, 32'h61, 1'b0);
        tick; row("fb_end",  1'b0, 4'd0, 32'h0,  1'b0);

        // Fill to full with grant withheld; fifth enqueue is dropped
        RST = 1'b1; tick; RST = 1'b0;
        RF_GNT = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) enq(1'b0, 1'b1, 4'(2 * i), {32'(32'hA0 + i), 32'(32'hB0 + i)});
            else       enq(1'b0, 1'b1, 4'd14, {32'hC0, 32'hC0});
            tick;
            if (i == 0) chk("full_stall_c1", 64'(DIV_STALL), 0);
            if (i == 1) chk("full_stall_c2", 64'(DIV_STALL), 1);
            if (i == 3) chk("full_ovf_before", 64'(OVERFLOW), 0);
            if (i == 4) chk("full_ovf_after", 64'(OVERFLOW), 1);
        end
        clr;
        RF_GNT = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (RF_WE) begin
                wr_a.push_back(RF_WADDR);
                wr_d.push_back(RF_WDATA);
            end
            tick;
        end
        chk("full_nwrites", 64'(wr_a.size()), 8);
        for (int w = 0; w < 8 && w < wr_a.size(); w++) begin
            chk($sformatf("full_w%0d_addr", w), 64'(wr_a[w]), 64'(w));
            chk($sformatf("full_w%0d_data", w), 64'(wr_d[w]),
                (w % 2 == 0) ? 64'(32'hB0 + w / 2) : 64'(32'hA0 + w / 2));
        end
        chk("full_ovf_sticky", 64'(OVERFLOW), 1);
        chk("full_stall_drained", 64'(DIV_STALL), 0);

        // Reset while in HI with three entries pending
        RST = 1'b1; tick; RST = 1'b0;
        RF_GNT = 1'b1;
        enq(1'b1, 1'b1, 4'd8, 64'h0000_0003_0000_0005); tick;
        enq(1'b0, 1'b1, 4'd10, 64'h1); tick;
        row("rh_lo", 1'b1, 4'd8, 32'h5, 1'b0);
        enq(1'b0, 1'b1, 4'd12, 64'h2); tick;
        clr;
        row("rh_hi", 1'b1, 4'd9, 32'h3, 1'b1);
        chk("rh_stall_pre", 64'(DIV_STALL), 1);
        RST = 1'b1;
        tick;
        RST = 1'b0;
        chk("rh_we", 64'(RF_WE), 0);
        chk("rh_stall", 64'(DIV_STALL), 0);
        chk("rh_flags", 64'({FLAG_WE, FLAG_N, FLAG_Z, OVERFLOW}), 0);
        late_writes = 0;
        for (int c = 0; c < 8; c++) begin
            tick;
            if (RF_WE) late_writes++;
        end
        chk("rh_no_writes", 64'(late_writes), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
